fifo_flex: RTL and testbench
============================

// Module: fifo_flex
// PURPOSE
//  Next-generation synchronous FIFO for GPU pipeline stage decoupling (command, vertex, texel queues).
//  - Arbitrary (non-power-of-2) depth.
//  - Selectable show-ahead or registered read.
//  - Programmable almost-full / almost-empty watermarks and occupancy output.
//  - Sticky overflow/underflow error flags and synchronous flush.
//  - Write-through-when-full when a read is accepted in the same cycle.
// PARAMETERS
//  DATA_WIDTH  32  width of each stored word
//  DEPTH       16  number of entries; any integer >= 2
//  SHOW_AHEAD  1   1: o_r_data shows head word combinationally; 0: o_r_data registered, 1-cycle read latency
//  AF_THRESH   DEPTH-2  o_almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
//  AE_THRESH   1   o_almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1
// PORTS
//  clk           in   1           clock, all logic on rising edge
//  rst_n         in   1           asynchronous active-low reset
//  i_flush       in   1           synchronous flush: empties FIFO
//  i_wr_en       in   1           write request
//  i_w_data      in   DATA_WIDTH  write data
//  i_rd_en       in   1           read (pop) request
//  o_r_data      out  DATA_WIDTH  read data; see BEHAVIOUR for timing
//  o_r_valid     out  1           o_r_data is meaningful
//  o_full        out  1           count == DEPTH
//  o_empty       out  1           count == 0
//  o_almost_full out  1           count >= AF_THRESH
//  o_almost_empty out 1           count <= AE_THRESH
//  o_count       out  CW          occupancy; CW = $clog2(DEPTH+1)
//  o_overflow    out  1           sticky: a write was rejected
//  o_underflow   out  1           sticky: a read was rejected
//  i_clr_err     in   1           clears both sticky flags next edge
// BEHAVIOUR
//  - Reset values: count 0, both pointers 0, o_empty 1, o_full 0, o_almost_empty 1, o_almost_full 0,
//    o_overflow 0, o_underflow 0, o_r_valid 0, o_r_data 0 (registered mode). Memory is not reset.
//  - Read acceptance: rd_acc = i_rd_en & !o_empty.
//  - Write acceptance: wr_acc = i_wr_en & (!o_full | rd_acc).
//    - When full, a write is accepted only together with an accepted read.
//    - When empty, a simultaneous read is rejected and the write is accepted.
//  - Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
//  - Flags and watermarks are decoded from registered count; no combinational path from inputs.
//  - Pointers wrap explicitly: DEPTH-1 -> 0 (no reliance on power-of-2 rollover).
//  - Write-through at full: mem[wr_ptr] is written while head word mem[rd_ptr] is popped.
//    At full, wr_ptr == rd_ptr, so the popped word must be the old contents; memory write is at the edge.
//  - SHOW_AHEAD=1:
//    - o_r_data = mem[rd_ptr]; o_r_valid = !o_empty.
//    - Data is valid in the same cycle rd_acc is sampled.
//  - SHOW_AHEAD=0:
//    - On rd_acc, o_r_data <= mem[rd_ptr] and o_r_valid <= 1 at the next edge; otherwise o_r_valid <= 0.
//    - o_r_data holds its last value while o_r_valid is 0.
//  - Errors:
//    - o_overflow sets on i_wr_en & !wr_acc; o_underflow sets on i_rd_en & !rd_acc.
//    - i_clr_err clears both flags. A set and a clear in the same cycle: set wins.
//  - Flush (i_flush=1): highest priority.
//    - Next edge: pointers 0, count 0, o_r_valid 0.
//    - Same-cycle wr/rd requests are discarded and raise no error flags. Memory contents are untouched.
//  - Async reset mid-operation forces all reset values immediately. First accepted write after rst_n
//    deasserts is stored at entry 0.
// STRUCTURE
//  - Package fifo_pkg: function wrap_inc(ptr, depth); localparam helpers for pointer width
//    (max(1,$clog2(DEPTH))) and count width.
//  - Sub-module fifo_wrap_ptr: modulo-DEPTH pointer register with inc and clr inputs; instantiated for rd and wr.
//  - Top level holds storage array, count, flags, error logic and the SHOW_AHEAD generate block.
// TESTING (DATA_WIDTH=8, DEPTH=5, AF_THRESH=4, AE_THRESH=1, SHOW_AHEAD=1 unless noted)
//  1 Fill: write 0x10..0x14 -> count 5, full 1, almost_full from count 4; 6th write 0x15 -> overflow 1,
//    count stays 5, 0x15 never read.
//  2 Wrap: fill 5, read 3, write 0xA0..0xA2, read 5 -> order 0x13,0x14,0xA0,0xA1,0xA2; empty 1.
//  3 Full + wr + rd same cycle: full with 0x10..0x14, push 0x55 while popping -> pop 0x10, count 5,
//    overflow 0; drain returns 0x11..0x14,0x55.
//  4 Empty: rd only -> underflow 1, count 0; wr 0x33 + rd same cycle -> count 1, head 0x33;
//    i_clr_err -> flags 0 next cycle.
//  5 Flush: count 3, assert i_flush with i_wr_en=1 -> next cycle count 0, empty 1, almost_empty 1,
//    no error flags; next write 0x77 reads back 0x77.
//  6 SHOW_AHEAD=0: write 0x21,0x22; rd_en two cycles -> o_r_valid high in cycles +1 and +2 with 0x21, 0x22;
//    async reset mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the flexible FIFO: pointer/count width math and the
// modulo-DEPTH pointer increment used for non-power-of-2 depths.
package fifo_pkg;

  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap at depth-1 so arbitrary depths never rely on binary rollover
  function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer register; clear has priority over increment.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = PW'(wrap_inc(32'(ptr_q), DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_flex.sv
// Synchronous FIFO with arbitrary depth, show-ahead or registered read,
// watermarks, sticky error flags, flush and write-through when full.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int SHOW_AHEAD = 1,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1,
  localparam int CW        = count_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_w_data,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_r_data,
  output logic                  o_r_valid,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [CW-1:0]         o_count,
  output logic                  o_overflow,
  output logic                  o_underflow,
  input  logic                  i_clr_err
);

  localparam int PW = ptr_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rdPtr, wrPtr;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rdAcc, wrAcc;

  // At full, a write is only legal when the head is popped in the same cycle
  assign rdAcc = i_rd_en && (count_q != '0);
  assign wrAcc = i_wr_en && ((count_q != CW'(DEPTH)) || rdAcc);

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) uRdPtr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (i_flush),
    .inc_i (rdAcc),
    .ptr_o (rdPtr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) uWrPtr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (i_flush),
    .inc_i (wrAcc),
    .ptr_o (wrPtr)
  );

  always_ff @(posedge clk) begin
    if (wrAcc && !i_flush) begin
      mem[wrPtr] <= i_w_data;
    end
  end

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (i_clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (i_flush) begin
      count_d = '0;
    end else begin
      if (wrAcc && !rdAcc) begin
        count_d = count_q + CW'(1);
      end else if (rdAcc && !wrAcc) begin
        count_d = count_q - CW'(1);
      end
      // Setting after the clear lets a new error win over i_clr_err
      if (i_wr_en && !wrAcc) overflow_d  = 1'b1;
      if (i_rd_en && !rdAcc) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_count        = count_q;
  assign o_empty        = (count_q == '0);
  assign o_full         = (count_q == CW'(DEPTH));
  assign o_almost_full  = (count_q >= CW'(AF_THRESH));
  assign o_almost_empty = (count_q <= CW'(AE_THRESH));
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

  if (SHOW_AHEAD != 0) begin : gShowAhead
    assign o_r_data  = mem[rdPtr];
    assign o_r_valid = (count_q != '0);
  end else begin : gRegistered
    logic [DATA_WIDTH-1:0] rData_q;
    logic                  rValid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rData_q  <= '0;
        rValid_q <= 1'b0;
      end else if (i_flush) begin
        rValid_q <= 1'b0;
      end else begin
        rValid_q <= rdAcc;
        if (rdAcc) rData_q <= mem[rdPtr];
      end
    end

    assign o_r_data  = rData_q;
    assign o_r_valid = rValid_q;
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Self-checking bench for fifo_flex: show-ahead and registered instances share
// stimulus and are compared against a queue-based reference model.
module tb_fifo_flex;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, wrEn, rdEn, clrErr;
  logic [DW-1:0] wData;

  logic [DW-1:0] saData, rgData;
  logic          saValid, rgValid;
  logic          saFull, saEmpty, saAf, saAe, saOvf, saUnf;
  logic          rgFull, rgEmpty, rgAf, rgAe, rgOvf, rgUnf;
  logic [CW-1:0] saCount, rgCount;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] modelQ[$];
  logic          mOvf, mUnf, mRegValid;
  logic [DW-1:0] mRegData;

  always #5 clk = ~clk;

  fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SHOW_AHEAD(1), .AF_THRESH(AF), .AE_THRESH(AE)) dutSa (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_wr_en(wrEn), .i_w_data(wData),
    .i_rd_en(rdEn), .o_r_data(saData), .o_r_valid(saValid), .o_full(saFull),
    .o_empty(saEmpty), .o_almost_full(saAf), .o_almost_empty(saAe), .o_count(saCount),
    .o_overflow(saOvf), .o_underflow(saUnf), .i_clr_err(clrErr)
  );

  fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SHOW_AHEAD(0), .AF_THRESH(AF), .AE_THRESH(AE)) dutReg (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_wr_en(wrEn), .i_w_data(wData),
    .i_rd_en(rdEn), .o_r_data(rgData), .o_r_valid(rgValid), .o_full(rgFull),
    .o_empty(rgEmpty), .o_almost_full(rgAf), .o_almost_empty(rgAe), .o_count(rgCount),
    .o_overflow(rgOvf), .o_underflow(rgUnf), .i_clr_err(clrErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic resetModel();
    modelQ.delete();
    mOvf      = 1'b0;
    mUnf      = 1'b0;
    mRegValid = 1'b0;
    mRegData  = '0;
  endtask

  // Compare both instances against the model's current state
  task automatic checkAll();
    int n;
    n = modelQ.size();
    checkOutput("count",      32'(saCount), 32'(n));
    checkOutput("empty",      32'(saEmpty), 32'(n == 0));
    checkOutput("full",       32'(saFull),  32'(n == DEPTH));
    checkOutput("almostFull", 32'(saAf),    32'(n >= AF));
    checkOutput("almostEmpt", 32'(saAe),    32'(n <= AE));
    checkOutput("overflow",   32'(saOvf),   32'(mOvf));
    checkOutput("underflow",  32'(saUnf),   32'(mUnf));
    checkOutput("saValid",    32'(saValid), 32'(n != 0));
    if (n != 0) checkOutput("saData", 32'(saData), 32'(modelQ[0]));
    checkOutput("rgCount",    32'(rgCount), 32'(n));
    checkOutput("rgFlags",    {28'd0, rgFull, rgEmpty, rgOvf, rgUnf},
                {28'd0, n == DEPTH, n == 0, mOvf, mUnf});
    checkOutput("rgWmarks",   {30'd0, rgAf, rgAe}, {30'd0, n >= AF, n <= AE});
    checkOutput("rgValid",    32'(rgValid), 32'(mRegValid));
    checkOutput("rgData",     32'(rgData),  32'(mRegData));
  endtask

  // Drive one cycle of requests, advance the model from the pre-edge state, then check
  task automatic applyStimulus(input logic f, input logic w, input logic [DW-1:0] d,
                               input logic r, input logic c);
    logic rdAcc, wrAcc;
    flush  = f;
    wrEn   = w;
    wData  = d;
    rdEn   = r;
    clrErr = c;
    rdAcc = r && (modelQ.size() > 0);
    wrAcc = w && ((modelQ.size() < DEPTH) || rdAcc);
    if (c) begin
      mOvf = 1'b0;
      mUnf = 1'b0;
    end
    if (f) begin
      modelQ.delete();
      mRegValid = 1'b0;
    end else begin
      mRegValid = rdAcc;
      if (rdAcc) mRegData = modelQ.pop_front();
      if (wrAcc) modelQ.push_back(d);
      if (w && !wrAcc) mOvf = 1'b1;
      if (r && !rdAcc) mUnf = 1'b1;
    end
    @(posedge clk);
    #1;
    flush  = 1'b0;
    wrEn   = 1'b0;
    rdEn   = 1'b0;
    clrErr = 1'b0;
    checkAll();
  endtask

  task automatic pushWord(input logic [DW-1:0] d);
    applyStimulus(1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic popWord();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic clearAll();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    flush = 0; wrEn = 0; rdEn = 0; clrErr = 0; wData = '0;
    rst_n = 1'b0;
    resetModel();
    #1;
    checkAll();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill, then overflow attempt
    for (int i = 0; i < DEPTH; i++) pushWord(8'h10 + 8'(i));
    checkOutput("s1_full", 32'(saFull), 32'd1);
    pushWord(8'h15);
    checkOutput("s1_ovf", 32'(saOvf), 32'd1);
    checkOutput("s1_count", 32'(saCount), 32'd5);
    for (int i = 0; i < DEPTH; i++) popWord();
    checkOutput("s1_lastPop", 32'(rgData), 32'h14);
    clearAll();

    // Pointer wrap
    for (int i = 0; i < DEPTH; i++) pushWord(8'h10 + 8'(i));
    for (int i = 0; i < 3; i++) popWord();
    for (int i = 0; i < 3; i++) pushWord(8'hA0 + 8'(i));
    checkOutput("s2_head", 32'(saData), 32'h13);
    for (int i = 0; i < DEPTH; i++) popWord();
    checkOutput("s2_empty", 32'(saEmpty), 32'd1);
    checkOutput("s2_last", 32'(rgData), 32'hA2);
    clearAll();

    // Write-through at full
    for (int i = 0; i < DEPTH; i++) pushWord(8'h10 + 8'(i));
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    checkOutput("s3_popOld", 32'(rgData), 32'h10);
    checkOutput("s3_ovf", 32'(saOvf), 32'd0);
    for (int i = 0; i < DEPTH; i++) popWord();
    checkOutput("s3_tail", 32'(rgData), 32'h55);
    clearAll();

    // Empty corner cases and error clear
    popWord();
    checkOutput("s4_unf", 32'(saUnf), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
    checkOutput("s4_head", 32'(saData), 32'h33);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("s4_clr", {30'd0, saOvf, saUnf}, 32'd0);
    popWord();

    // Flush discards same-cycle requests
    for (int i = 0; i < 3; i++) pushWord(8'h60 + 8'(i));
    applyStimulus(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
    checkOutput("s5_count", 32'(saCount), 32'd0);
    pushWord(8'h77);
    popWord();
    checkOutput("s5_read", 32'(rgData), 32'h77);

    // Registered-read timing, then async reset mid-stream
    pushWord(8'h21);
    pushWord(8'h22);
    popWord();
    checkOutput("s6_first", {31'd0, rgValid} << 8 | 32'(rgData), 32'h121);
    popWord();
    checkOutput("s6_second", {31'd0, rgValid} << 8 | 32'(rgData), 32'h122);
    pushWord(8'h30);
    pushWord(8'h31);
    wrEn = 1'b1; wData = 8'h32;
    #2;
    rst_n = 1'b0;
    resetModel();
    #1;
    wrEn = 1'b0;
    checkAll();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pushWord(8'h40);
    checkOutput("s6_afterRst", 32'(saData), 32'h40);
    popWord();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 40) == 0, ($urandom % 100) < 55, 8'($urandom),
                    ($urandom % 100) < 48, ($urandom % 20) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
